// File: rtl/FPU_pkg.sv
// Shared FPU result types and fflags bit positions used by the result arbiter.
package FPU_pkg;

  // fflags bit positions inside the 5-bit {NV,DZ,OF,UF,NX} field
  localparam int FFLAG_NV = 4;
  localparam int FFLAG_DZ = 3;
  localparam int FFLAG_OF = 2;
  localparam int FFLAG_UF = 1;
  localparam int FFLAG_NX = 0;

  localparam int FLAGS_W = 5;

  // One execution-unit result: raw 32-bit float plus its exception flags
  typedef struct packed {
    logic [31:0]        value;
    logic [FLAGS_W-1:0] flags;
  } fpu_result_t;

endpackage

// File: rtl/fpu_result_arbiter_rr_arbiter.sv
// Wrap-around priority search: starting at ptr_i and moving upward (wrapping
// from N-1 to 0), the first asserted request wins. Purely combinational.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  // One extra bit so ptr + offset can exceed N-1 before the wrap is applied
  localparam logic [IW:0] NL = (IW+1)'(N);

  logic [IW:0] cand;

  // Scan all N positions starting at the pointer; keep the first hit
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    cand  = '0;
    for (int k = 0; k < N; k++) begin
      cand = {1'b0, ptr_i} + (IW+1)'(k);
      if (cand >= NL) begin
        cand = cand - NL;
      end
      if (!any_o && req_i[cand[IW-1:0]]) begin
        any_o                = 1'b1;
        gnt_o[cand[IW-1:0]]  = 1'b1;
        idx_o                = cand[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/fpu_result_arbiter.sv
// FPU result arbiter: picks one of N_UNITS execution-unit results per cycle
// (round-robin) into a single registered writeback slot with valid/ready flow.
// Optional feature macro FPU_ARB_FLAGS_EN: when defined the selected fflags
// are registered and driven on fflags_out; otherwise flags_in is ignored and
// fflags_out is constant zero.
module fpu_result_arbiter
  import FPU_pkg::*;
#(
  parameter  int N_UNITS = 4,
  localparam int IW      = $clog2(N_UNITS)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            flush,
  input  logic [N_UNITS-1:0]              valid_in,
  output logic [N_UNITS-1:0]              ready_out,
  input  logic [N_UNITS-1:0][31:0]        data_in,
  input  logic [N_UNITS-1:0][FLAGS_W-1:0] flags_in,
  output logic                            valid_out,
  input  logic                            ready_in,
  output logic [31:0]                     float_out,
  output logic [FLAGS_W-1:0]              fflags_out,
  output logic [IW-1:0]                   src_out
);

  logic          valid_q, valid_d;
  logic [31:0]   value_q, value_d;
  logic [IW-1:0] src_q,   src_d;
  logic [IW-1:0] ptr_q,   ptr_d;

  logic [N_UNITS-1:0] gnt;
  logic [IW-1:0]      gnt_idx;
  logic               gnt_any;
  logic               slot_free;
  logic               grant;
  logic [IW-1:0]      ptr_next;
  fpu_result_t        sel;

  rr_arbiter #(
    .N  (N_UNITS),
    .IW (IW)
  ) u_rr (
    .req_i (valid_in),
    .ptr_i (ptr_q),
    .gnt_o (gnt),
    .idx_o (gnt_idx),
    .any_o (gnt_any)
  );

  // The slot can take a new result if it is empty or is being drained now.
  // Gating with reset keeps ready_out low while reset is held.
  assign slot_free = !valid_q || ready_in;
  assign grant     = gnt_any && slot_free && !flush && reset;
  assign ready_out = grant ? gnt : '0;

  // Pointer moves to the unit just after the winner, wrapping at N_UNITS-1
  assign ptr_next = (gnt_idx == IW'(N_UNITS - 1)) ? '0 : gnt_idx + 1'b1;

  assign sel.value = data_in[gnt_idx];
`ifdef FPU_ARB_FLAGS_EN
  assign sel.flags = flags_in[gnt_idx];
`else
  assign sel.flags = '0;
`endif

  // Next-state for the output slot: flush beats grant beats drain
  always_comb begin
    valid_d = valid_q;
    value_d = value_q;
    src_d   = src_q;
    ptr_d   = ptr_q;
    if (flush) begin
      valid_d = 1'b0;
      value_d = '0;
      src_d   = '0;
    end else if (grant) begin
      valid_d = 1'b1;
      value_d = sel.value;
      src_d   = gnt_idx;
      ptr_d   = ptr_next;
    end else if (valid_q && ready_in) begin
      valid_d = 1'b0;
      value_d = '0;
      src_d   = '0;
    end
  end

  // Output slot and round-robin pointer registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
      value_q <= '0;
      src_q   <= '0;
      ptr_q   <= '0;
    end else begin
      valid_q <= valid_d;
      value_q <= value_d;
      src_q   <= src_d;
      ptr_q   <= ptr_d;
    end
  end

`ifdef FPU_ARB_FLAGS_EN
  logic [FLAGS_W-1:0] flags_q, flags_d;

  // Flags follow the same flush/grant/drain priority as the data
  always_comb begin
    flags_d = flags_q;
    if (flush) begin
      flags_d = '0;
    end else if (grant) begin
      flags_d = sel.flags;
    end else if (valid_q && ready_in) begin
      flags_d = '0;
    end
  end

  // Registered flags of the result held in the slot
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flags_q <= '0;
    end else begin
      flags_q <= flags_d;
    end
  end

  assign fflags_out = flags_q;
`else
  logic [N_UNITS-1:0][FLAGS_W-1:0] unused_flags;
  logic [FLAGS_W-1:0]              unused_sel_flags;
  assign unused_flags     = flags_in;
  assign unused_sel_flags = sel.flags;
  assign fflags_out       = '0;
`endif

  assign valid_out = valid_q;
  assign float_out = value_q;
  assign src_out   = src_q;

endmodule

// File: tb/tb_fpu_result_arbiter.sv
// Scoreboard bench for fpu_result_arbiter (N_UNITS=4): the driver predicts
// grants from a round-robin model and queues expected results; a separate
// monitor compares the writeback slot against the queue front every cycle.
module tb_fpu_result_arbiter;

  localparam int N = 4;

`ifdef FPU_ARB_FLAGS_EN
  localparam bit FL_EN = 1'b1;
`else
  localparam bit FL_EN = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                reset;
  logic                flush;
  logic [N-1:0]        valid_in;
  logic [N-1:0]        ready_out;
  logic [N-1:0][31:0]  data_in;
  logic [N-1:0][4:0]   flags_in;
  logic                valid_out;
  logic                ready_in;
  logic [31:0]         float_out;
  logic [4:0]          fflags_out;
  logic [1:0]          src_out;

  fpu_result_arbiter #(.N_UNITS(N)) dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .valid_in   (valid_in),
    .ready_out  (ready_out),
    .data_in    (data_in),
    .flags_in   (flags_in),
    .valid_out  (valid_out),
    .ready_in   (ready_in),
    .float_out  (float_out),
    .fflags_out (fflags_out),
    .src_out    (src_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] v;
    logic [4:0]  f;
    int          s;
  } exp_t;

  exp_t               q[$];
  int                 total = 0;
  int                 bad   = 0;
  int                 rr    = 0;
  logic [N-1:0][31:0] d_set;
  logic [N-1:0][4:0]  f_set;
  logic [N-1:0]       last_ro;
  logic [4:0]         last_fl;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus. Grant prediction: slot free when nothing is
  // pending or the sink is ready; scan units from rr upward with wrap.
  task automatic step(input logic [N-1:0] v, input bit r, input bit f);
    int  g;
    bit  sf;
    exp_t e;
    @(negedge clk);
    reset    = 1'b1;
    valid_in = v;
    ready_in = r;
    flush    = f;
    data_in  = d_set;
    flags_in = f_set;
    #1;
    last_ro = ready_out;
    last_fl = fflags_out;
    sf = (q.size() == 0) || r;
    g  = -1;
    if (sf && !f) begin
      for (int k = 0; k < N; k++) begin
        if (v[(rr + k) % N]) begin
          g = (rr + k) % N;
          break;
        end
      end
    end
    chk("ready_out", {60'd0, ready_out}, (g >= 0) ? (64'd1 << g) : 64'd0);
    #3;
    if (g >= 0) begin
      e.v = d_set[g];
      e.f = FL_EN ? f_set[g] : 5'd0;
      e.s = g;
      q.push_back(e);
      rr = (g + 1) % N;
    end
  endtask

  // Assert reset mid-cycle with the given requests present
  task automatic do_reset(input logic [N-1:0] v);
    @(negedge clk);
    reset    = 1'b0;
    valid_in = v;
    ready_in = 1'b1;
    flush    = 1'b0;
    #1;
    chk("rst_valid_out", {63'd0, valid_out}, 64'd0);
    chk("rst_float_out", {32'd0, float_out}, 64'd0);
    chk("rst_fflags_out", {59'd0, fflags_out}, 64'd0);
    chk("rst_src_out", {62'd0, src_out}, 64'd0);
    chk("rst_ready_out", {60'd0, ready_out}, 64'd0);
    q.delete();
    rr = 0;
  endtask

  task automatic rand_data();
    for (int i = 0; i < N; i++) begin
      d_set[i] = $urandom;
      f_set[i] = 5'($urandom);
    end
  endtask

  // Monitor: slot contents must equal the oldest outstanding expected result
  initial begin
    forever begin
      @(negedge clk);
      #3;
      if (reset) begin
        if (q.size() > 0) begin
          chk("valid_out", {63'd0, valid_out}, 64'd1);
          chk("float_out", {32'd0, float_out}, {32'd0, q[0].v});
          chk("fflags_out", {59'd0, fflags_out}, {59'd0, q[0].f});
          chk("src_out", {62'd0, src_out}, 64'(q[0].s));
          if (flush || ready_in) void'(q.pop_front());
        end else begin
          chk("idle_valid_out", {63'd0, valid_out}, 64'd0);
          chk("idle_float_out", {32'd0, float_out}, 64'd0);
          chk("idle_fflags_out", {59'd0, fflags_out}, 64'd0);
          chk("idle_src_out", {62'd0, src_out}, 64'd0);
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset    = 1'b0;
    flush    = 1'b0;
    valid_in = '0;
    ready_in = 1'b0;
    data_in  = '0;
    flags_in = '0;
    d_set    = '0;
    f_set    = '0;
    do_reset(4'b1111);
    do_reset(4'b1111);

    // Single source: unit 2 wins, result appears next cycle, pointer moves to 3
    rand_data();
    d_set[2] = 32'h3F800000;
    f_set[2] = 5'd0;
    step(4'b0100, 1'b1, 1'b0);
    chk("single_ready", {60'd0, last_ro}, 64'b0100);
    step(4'b0000, 1'b1, 1'b0);
    step(4'b1111, 1'b1, 1'b0);
    chk("single_next_ptr3", {60'd0, last_ro}, 64'b1000);
    step(4'b0000, 1'b1, 1'b0);

    // Fairness from pointer 0: grants 0,1,2,3,0
    do_reset(4'b0000);
    rand_data();
    step(4'b1111, 1'b1, 1'b0);
    chk("fair_g0", {60'd0, last_ro}, 64'b0001);
    step(4'b1111, 1'b1, 1'b0);
    chk("fair_g1", {60'd0, last_ro}, 64'b0010);
    step(4'b1111, 1'b1, 1'b0);
    chk("fair_g2", {60'd0, last_ro}, 64'b0100);
    step(4'b1111, 1'b1, 1'b0);
    chk("fair_g3", {60'd0, last_ro}, 64'b1000);
    step(4'b1111, 1'b1, 1'b0);
    chk("fair_g0_again", {60'd0, last_ro}, 64'b0001);
    step(4'b0000, 1'b1, 1'b0);

    // Backpressure: slot full, sink stalls 3 cycles, unit 1 waits
    rand_data();
    step(4'b0001, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(4'b0010, 1'b0, 1'b0);
      chk("bp_stall_ready", {60'd0, last_ro}, 64'd0);
    end
    step(4'b0010, 1'b1, 1'b0);
    chk("bp_release_ready", {60'd0, last_ro}, 64'b0010);
    step(4'b0000, 1'b1, 1'b0);

    // Flush: slot holds -1.0, flush with unit 0 requesting; pointer kept
    rand_data();
    d_set[0] = 32'hBF800000;
    step(4'b0001, 1'b1, 1'b0);
    step(4'b0001, 1'b0, 1'b1);
    chk("flush_ready0", {60'd0, last_ro}, 64'd0);
    step(4'b0000, 1'b1, 1'b0);
    step(4'b1111, 1'b1, 1'b0);
    chk("flush_ptr_kept", {60'd0, last_ro}, 64'b0010);
    step(4'b0000, 1'b1, 1'b0);

    // Reset mid-stream with pointer at 2 and slot full
    rand_data();
    step(4'b0010, 1'b1, 1'b0);
    do_reset(4'b1001);
    step(4'b1001, 1'b1, 1'b0);
    chk("rst_first_grant_u0", {60'd0, last_ro}, 64'b0001);
    step(4'b0000, 1'b1, 1'b0);

    // Flags pass-through from unit 3
    rand_data();
    f_set[3] = 5'b10000;
    step(4'b1000, 1'b1, 1'b0);
    step(4'b0000, 1'b1, 1'b0);
    chk("flags_unit3", {59'd0, last_fl}, FL_EN ? 64'b10000 : 64'd0);

    // Randomized traffic
    for (int i = 0; i < 500; i++) begin
      rand_data();
      step(4'($urandom), ($urandom % 10) < 7, ($urandom % 20) == 0);
    end

    for (int i = 0; i < 4; i++) step(4'b0000, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
